carregador_matrizes: RTL and testbench
======================================

Name: carregador_matrizes

Overview:
- Upstream stage of the 5x5 signed-8-bit matrix multiplier.
- Accepts a byte stream over a valid/ready handshake and assembles matrix A, then matrix B, into the flat 200-bit row-major buses the multiplier consumes.
- Holds both matrices stable with a valid flag until the consumer releases them.
- Sits between the host/UART byte interface and the multiplier.

Parameters:
- N, 5, matrix dimension (rows = columns).
- W, 8, element width in bits (two's complement).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- dado_entrada  input  W  next element byte, row-major
- dado_valido  input  1  upstream asserts when dado_entrada is meaningful
- dado_pronto  output  1  loader can accept a byte this cycle
- cancela  input  1  synchronous abort of the current load, returns to empty
- liberado  input  1  consumer pulse: matrices used, loader may refill
- matriz_a  output  N*N*W  element (l,c) at bits W*(c+N*l) +: W
- matriz_b  output  N*N*W  same layout as matriz_a
- matrizes_validas  output  1  both matrices complete and stable
- contador  output  6  elements accepted in the current load, 0..2*N*N

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous, active-high, and sampled on the rising clock edge.
  - On reset: state = CARREGA_A, contador = 0, matriz_a = 0, matriz_b = 0, matrizes_validas = 0.
  - dado_pronto is 1 in the first cycle after reset deasserts.
- Transfer rule: a byte transfers on a rising edge where dado_valido && dado_pronto. No other edge writes an element.
- dado_pronto is 1 in CARREGA_A and CARREGA_B, and 0 in PRONTO. It is driven from registered state only, with no combinational path from dado_valido.
- Element placement:
  - Index k = contador.
  - For k < N*N, write matriz_a element (k/N, k%N).
  - Otherwise write matriz_b element ((k-N*N)/N, (k-N*N)%N).
  - Bytes are stored unmodified. Sign is interpreted only downstream.
- States:
  - CARREGA_A: each transfer writes A and increments contador. The transfer with contador == N*N-1 moves to CARREGA_B.
  - CARREGA_B: each transfer writes B and increments contador. The transfer with contador == 2*N*N-1 moves to PRONTO, and contador becomes 2*N*N.
  - PRONTO: matrizes_validas = 1. matriz_a and matriz_b are held bit-stable. Input bytes are ignored.
  - PRONTO exits on liberado == 1: next state CARREGA_A, contador = 0, matrizes_validas = 0. Matrix contents are retained, not cleared, until overwritten.
- Latency:
  - matrizes_validas rises on the edge that accepts the 50th byte, and is visible the following cycle.
  - The first new byte is accepted one cycle after the liberado edge at the earliest.
- Full back-to-back: at one byte per cycle, a 50-byte load takes 50 cycles with no bubbles.
- cancela:
  - In any state, cancela → CARREGA_A, contador = 0, matrizes_validas = 0. Matrices are not cleared.
  - A byte presented in the same cycle is discarded, even if dado_pronto was 1.
- Precedence: reset > cancela > liberado > data transfer.
- liberado outside PRONTO is ignored. liberado held high for several cycles releases only once, because the loader leaves PRONTO.
- Gaps: dado_valido low mid-load pauses loading indefinitely. No timeout.
- Reset mid-load: behaves identically to a reset from idle, and partial contents are zeroed.
- Width rule: contador is 6 bits, covering max value 50. Index arithmetic must not wrap inside a load.

Test Plan:
- Reset, then stream bytes 1..25 then 26..50, valid every cycle → matrizes_validas = 1 after the 50th edge; matriz_a[7:0] = 1, matriz_a[199:192] = 25, matriz_b[7:0] = 26, matriz_b[199:192] = 50; contador = 50; dado_pronto = 0.
- In PRONTO, drive dado_valido = 1 with 8'hFF for 10 cycles → matriz_a and matriz_b unchanged, contador stays 50.
- Pulse liberado for 3 cycles, then stream 50 bytes of 8'h80 → single release to CARREGA_A; all elements of both matrices = -128; matrizes_validas = 1 again.
- After 30 bytes, assert cancela together with a valid byte 8'h55 → contador = 0, matrizes_validas = 0, byte not stored. The next byte lands at matriz_a[7:0].
- Random dado_valido gaps (about 50% duty) over a full load → data placed identically to the back-to-back case. Assertion: dado_pronto == 0 whenever matrizes_validas == 1.
- Reset asserted at byte 12 → all outputs return to reset values on the next edge. A fresh 50-byte load completes correctly.

Source files
------------

// File: rtl/carregador_matrizes.sv
// Byte-stream loader for the 5x5 matrix multiplier: assembles A then B row-major
// and holds both stable with a valid flag until the consumer releases them.
module carregador_matrizes #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     dado_entrada,
  input  logic             dado_valido,
  output logic             dado_pronto,
  input  logic             cancela,
  input  logic             liberado,
  output logic [N*N*W-1:0] matriz_a,
  output logic [N*N*W-1:0] matriz_b,
  output logic             matrizes_validas,
  output logic [5:0]       contador
);

  localparam int unsigned NN = N * N;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_A = CW'(NN - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * NN - 1);

  typedef enum logic [1:0] {
    CARREGA_A,
    CARREGA_B,
    PRONTO
  } estado_t;

  estado_t          r_estado;
  estado_t          w_estado_prox;
  logic [CW-1:0]    r_contador;
  logic [CW-1:0]    w_contador_prox;
  logic             r_dado_pronto;
  logic             r_validas;
  logic [N*N*W-1:0] r_matriz_a;
  logic [N*N*W-1:0] r_matriz_b;
  logic             w_transfere;
  logic             w_escreve_a;
  logic             w_escreve_b;

  // Next-state, counter and write-enable decode; cancela overrides everything but reset.
  always_comb begin
    w_estado_prox   = r_estado;
    w_contador_prox = r_contador;
    w_escreve_a     = 1'b0;
    w_escreve_b     = 1'b0;
    w_transfere     = dado_valido && r_dado_pronto;
    if (cancela) begin
      w_estado_prox   = CARREGA_A;
      w_contador_prox = '0;
    end else begin
      case (r_estado)
        CARREGA_A: begin
          if (w_transfere) begin
            w_escreve_a     = 1'b1;
            w_contador_prox = r_contador + CW'(1);
            if (r_contador == LAST_A) w_estado_prox = CARREGA_B;
          end
        end
        CARREGA_B: begin
          if (w_transfere) begin
            w_escreve_b     = 1'b1;
            w_contador_prox = r_contador + CW'(1);
            if (r_contador == LAST_B) w_estado_prox = PRONTO;
          end
        end
        PRONTO: begin
          if (liberado) begin
            w_estado_prox   = CARREGA_A;
            w_contador_prox = '0;
          end
        end
        default: begin
          w_estado_prox   = CARREGA_A;
          w_contador_prox = '0;
        end
      endcase
    end
  end

  // State register; ready and valid flags are registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado      <= CARREGA_A;
      r_contador    <= '0;
      r_dado_pronto <= 1'b1;
      r_validas     <= 1'b0;
    end else begin
      r_estado      <= w_estado_prox;
      r_contador    <= w_contador_prox;
      r_dado_pronto <= (w_estado_prox != PRONTO);
      r_validas     <= (w_estado_prox == PRONTO);
    end
  end

  // Element storage: slot k of A or slot k-NN of B, selected by the counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_matriz_a <= '0;
      r_matriz_b <= '0;
    end else begin
      for (int unsigned e = 0; e < NN; e++) begin
        if (w_escreve_a && (r_contador == CW'(e)))
          r_matriz_a[W*e +: W] <= dado_entrada;
        if (w_escreve_b && (r_contador == CW'(NN + e)))
          r_matriz_b[W*e +: W] <= dado_entrada;
      end
    end
  end

  assign dado_pronto      = r_dado_pronto;
  assign matrizes_validas = r_validas;
  assign contador         = r_contador;
  assign matriz_a         = r_matriz_a;
  assign matriz_b         = r_matriz_b;

endmodule

// File: tb/tb_carregador_matrizes.sv
// Self-checking bench for carregador_matrizes: cycle model plus a scoreboard of
// completed matrix pairs checked when matrizes_validas rises.
module tb_carregador_matrizes;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 8;
  localparam int unsigned NN = N * N;
  localparam int unsigned MB = NN * W;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  dado_entrada;
  logic          dado_valido;
  logic          dado_pronto;
  logic          cancela;
  logic          liberado;
  logic [MB-1:0] matriz_a;
  logic [MB-1:0] matriz_b;
  logic          matrizes_validas;
  logic [5:0]    contador;

  carregador_matrizes #(.N(N), .W(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .dado_entrada     (dado_entrada),
    .dado_valido      (dado_valido),
    .dado_pronto      (dado_pronto),
    .cancela          (cancela),
    .liberado         (liberado),
    .matriz_a         (matriz_a),
    .matriz_b         (matriz_b),
    .matrizes_validas (matrizes_validas),
    .contador         (contador)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0]      m_a [NN];
  logic [W-1:0]      m_b [NN];
  int                m_cnt = 0;
  logic [2*MB-1:0]   sb_q [$];
  bit                mon_en = 1'b0;
  logic              prev_v = 1'b0;

  task automatic check_val(input string tag, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [MB-1:0] pack_a();
    logic [MB-1:0] r;
    for (int e = 0; e < NN; e++) r[W*e +: W] = m_a[e];
    return r;
  endfunction

  function automatic logic [MB-1:0] pack_b();
    logic [MB-1:0] r;
    for (int e = 0; e < NN; e++) r[W*e +: W] = m_b[e];
    return r;
  endfunction

  // One clock: drive inputs, advance the model at the edge, release controls.
  task automatic step(input bit v, input logic [W-1:0] b, input bit canc = 0,
                      input bit lib = 0, input bit rst = 0);
    dado_valido  = v;
    dado_entrada = b;
    cancela      = canc;
    liberado     = lib;
    reset        = rst;
    @(posedge clock);
    if (rst) begin
      m_cnt = 0;
      for (int e = 0; e < NN; e++) begin
        m_a[e] = '0;
        m_b[e] = '0;
      end
    end else if (canc) begin
      m_cnt = 0;
    end else if (m_cnt == 2 * NN) begin
      if (lib) m_cnt = 0;
    end else if (v) begin
      if (m_cnt < NN) m_a[m_cnt] = b;
      else            m_b[m_cnt - NN] = b;
      m_cnt++;
      if (m_cnt == 2 * NN) sb_q.push_back({pack_a(), pack_b()});
    end
    #1;
    dado_valido = 1'b0;
    cancela     = 1'b0;
    liberado    = 1'b0;
    reset       = 1'b0;
  endtask

  // Per-cycle comparison against the model, plus scoreboard pop on valid rise.
  always @(negedge clock) begin
    if (mon_en) begin
      check_val("contador", MB'(contador), MB'(m_cnt));
      check_val("validas", MB'(matrizes_validas), MB'(m_cnt == 2 * NN));
      check_val("pronto", MB'(dado_pronto), MB'(m_cnt != 2 * NN));
      check_val("pronto_excl_validas", MB'(dado_pronto & matrizes_validas), '0);
      check_val("matriz_a", matriz_a, pack_a());
      check_val("matriz_b", matriz_b, pack_b());
      if (matrizes_validas && !prev_v) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_valid", MB'(1), MB'(0));
        end else begin
          logic [2*MB-1:0] exp;
          exp = sb_q.pop_front();
          check_val("sb_a", matriz_a, exp[2*MB-1:MB]);
          check_val("sb_b", matriz_b, exp[MB-1:0]);
        end
      end
      prev_v = matrizes_validas;
    end
  end

  initial begin
    dado_valido  = 1'b0;
    dado_entrada = '0;
    cancela      = 1'b0;
    liberado     = 1'b0;
    reset        = 1'b1;
    for (int e = 0; e < NN; e++) begin
      m_a[e] = '0;
      m_b[e] = '0;
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    check_val("reset_pronto", MB'(dado_pronto), MB'(1));
    check_val("reset_contador", MB'(contador), MB'(0));

    // Back-to-back load 1..50
    for (int i = 1; i <= 50; i++) step(1, W'(i));
    check_val("a_first", MB'(matriz_a[7:0]), MB'(1));
    check_val("a_last", MB'(matriz_a[199:192]), MB'(25));
    check_val("b_first", MB'(matriz_b[7:0]), MB'(26));
    check_val("b_last", MB'(matriz_b[199:192]), MB'(50));
    check_val("full_contador", MB'(contador), MB'(50));
    check_val("full_pronto", MB'(dado_pronto), MB'(0));

    // Bytes ignored while holding
    for (int i = 0; i < 10; i++) step(1, 8'hFF);
    check_val("hold_b_last", MB'(matriz_b[199:192]), MB'(50));

    // Liberado held 3 cycles releases once, then a load of 0x80
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check_val("released_contador", MB'(contador), MB'(0));
    for (int i = 0; i < 50; i++) step(1, 8'h80);
    check_val("neg128_a", matriz_a, {NN{8'h80}});
    check_val("neg128_b", matriz_b, {NN{8'h80}});
    check_val("neg128_valid", MB'(matrizes_validas), MB'(1));

    // Cancel after 30 bytes with a simultaneous byte
    step(0, 0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, W'(100 + i));
    step(1, 8'h55, 1);
    check_val("cancel_contador", MB'(contador), MB'(0));
    check_val("cancel_b0_kept", MB'(matriz_b[7:0]), MB'(100 + 25));
    step(1, 8'hA7);
    check_val("after_cancel_a0", MB'(matriz_a[7:0]), MB'(8'hA7));

    // Random gaps over a full load, values 1..50 from a fresh start
    step(0, 0, 1);
    for (int i = 1; i <= 50; i++) begin
      while ($urandom_range(1, 0) == 0) step(0, 8'hEE);
      step(1, W'(i));
    end
    check_val("gaps_a_last", MB'(matriz_a[199:192]), MB'(25));
    check_val("gaps_b_first", MB'(matriz_b[7:0]), MB'(26));

    // Reset mid-load at byte 12, then a fresh load
    step(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, W'(200 + i));
    step(1, 8'h11, 0, 0, 1);
    check_val("rst_a", matriz_a, '0);
    check_val("rst_b", matriz_b, '0);
    check_val("rst_contador", MB'(contador), MB'(0));
    check_val("rst_pronto", MB'(dado_pronto), MB'(1));
    for (int i = 0; i < 50; i++) step(1, W'(3 * i + 7));
    check_val("fresh_valid", MB'(matrizes_validas), MB'(1));
    check_val("fresh_b_last", MB'(matriz_b[199:192]), MB'(3 * 49 + 7));
    step(0, 0);
    check_val("sb_drained", MB'(sb_q.size()), MB'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
